// File: rtl/arch_defs_pkg.sv
// Shared bus architecture constants and the MMIO FIFO port register layout.
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [15:0] MMIO_FIFO_BASE = 16'hE000;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_RX_OVF   = 4;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

    typedef struct packed {
        logic [2:0] rsvd;
        logic       rx_ovf;
        logic       tx_ovf;
        logic       rx_empty;
        logic       tx_full;
        logic       tx_empty;
    } status_t;

endpackage

// File: rtl/mmio_fifo_port_if.sv
// CPU memory bus plus TX/RX byte streams seen by the MMIO FIFO port.
interface mmio_fifo_port_if;
    import arch_defs_pkg::*;

    logic [15:0]           mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_hit;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_data_in,
        output mem_data_out, mem_hit,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_data_in,
        input  mem_data_out, mem_hit,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready
    );

endinterface

// File: rtl/sync_byte_fifo.sv
// Single-clock FIFO; a pop in the same edge frees room for a push, flush beats traffic.
module sync_byte_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_fifo_port.sv
// Memory-mapped responder exposing a TX and an RX byte FIFO in a 4-byte window.
// Read data is registered (1 cycle); stream sides use valid/ready, rx_ready = RX not full.
module mmio_fifo_port #(
    parameter logic [15:0] BASE_ADDR  = arch_defs_pkg::MMIO_FIFO_BASE,
    parameter int          DEPTH      = 8,
    parameter int          DATA_WIDTH = arch_defs_pkg::DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    mmio_fifo_port_if.slave  bus
);
    import arch_defs_pkg::*;

    logic                  hit;
    logic [1:0]            offset;
    logic                  rd;
    logic                  wr;
    logic                  wr_data;
    logic                  wr_ctrl;
    logic                  rd_data;
    logic                  flush;
    logic                  clr_ovf;

    logic                  tx_full;
    logic                  tx_empty;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  rx_full;
    logic                  rx_empty;
    logic [DATA_WIDTH-1:0] rx_head;

    logic                  tx_ovf;
    logic                  rx_ovf;
    status_t               status;
    logic [DATA_WIDTH-1:0] rd_val;

    assign hit    = (bus.mem_address[15:2] == BASE_ADDR[15:2]);
    assign offset = bus.mem_address[1:0];

    // A write wins if both strobes are ever seen together.
    assign wr      = bus.mem_write & hit;
    assign rd      = bus.mem_read & ~bus.mem_write & hit;
    assign wr_data = wr & (offset == REG_DATA);
    assign wr_ctrl = wr & (offset == REG_CTRL);
    assign rd_data = rd & (offset == REG_DATA);
    assign flush   = wr_ctrl & bus.mem_data_in[CTRL_FLUSH];
    assign clr_ovf = wr_ctrl & bus.mem_data_in[CTRL_CLR_OVF];

    sync_byte_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_data),
        .push_data (bus.mem_data_in),
        .pop       (bus.tx_ready),
        .flush     (flush),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    sync_byte_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.rx_valid & bus.rx_ready),
        .push_data (bus.rx_data),
        .pop       (rd_data),
        .flush     (flush),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    assign bus.tx_data  = tx_head;
    assign bus.tx_valid = ~tx_empty;
    assign bus.rx_ready = ~rx_full;

    // A full TX only drops the byte when no pop makes room in the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            tx_ovf <= (tx_ovf & ~clr_ovf) | (wr_data & tx_full & ~bus.tx_ready);
            rx_ovf <= (rx_ovf & ~clr_ovf) | (bus.rx_valid & rx_full);
        end
    end

    always_comb begin
        status          = '0;
        status.rx_ovf   = rx_ovf;
        status.tx_ovf   = tx_ovf;
        status.rx_empty = rx_empty;
        status.tx_full  = tx_full;
        status.tx_empty = tx_empty;
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            REG_DATA:   rd_val = rx_head;
            REG_STATUS: rd_val = status;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_hit      <= 1'b0;
            bus.mem_data_out <= '0;
        end else if (rd) begin
            bus.mem_hit      <= 1'b1;
            bus.mem_data_out <= rd_val;
        end else begin
            bus.mem_hit      <= 1'b0;
        end
    end

endmodule
